// File: rtl/shift_add_multiplier.sv
// Iterative 32-bit unsigned shift-and-add multiplier producing the low N bits of a*b.
// One multiplier bit is consumed per cycle through a combinational left shifter.

module shift_left_logical #(
  parameter int N = 32
) (
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         out
);
  assign out = in << shamt;
endmodule

module shift_add_multiplier #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] product,
  output logic         busy
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. in_ready/out_valid depend on state only; producers hold data until taken.

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   product_q, product_d;
  logic [N-1:0]   shifted;
  logic [N-1:0]   acc_sum;
  logic           last_iter;

  shift_left_logical #(.N(N)) u_sll (
    .in    (a_q),
    .shamt (cnt_q),
    .out   (shifted)
  );

  assign acc_sum   = acc_q + (b_q[0] ? shifted : '0);
  // Stop once no set bits remain above the current one, or at the final bit.
  assign last_iter = (b_q[N-1:1] == '0) || (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
    product   = product_q;
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (state_q == IDLE && in_valid) begin
      a_d   = a;
      b_d   = b;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      acc_d = acc_sum;
      b_d   = b_q >> 1;
      if (last_iter) product_d = acc_sum;
      else           cnt_d     = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed-vector bench for shift_add_multiplier: latency, product, backpressure,
// ignored input while busy, and asynchronous reset mid-operation.

module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int n_checks;
  int n_errors;

  shift_add_multiplier #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE. stall = cycles to hold out_ready low in DONE.
  task automatic do_mul(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_p, input int exp_n, input int stall);
    int n;
    out_ready = (stall == 0);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      n++;
      in_valid = n[0];
      a        = $urandom;
      b        = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, ".busy_cycles"}, n, exp_n);
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".product"}, product, exp_p);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      @(negedge clk);
      check({tag, ".stall_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".stall_product"}, product, exp_p);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, ".idle_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".idle_product"}, product, exp_p);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.product", product, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_mul("basic",   32'd3,        32'd5,        32'd15,       3,  0);
    do_mul("zero_b",  32'hDEADBEEF, 32'd0,        32'd0,        1,  0);
    do_mul("full",    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 0);
    do_mul("wrap",    32'h00010000, 32'h00010000, 32'h00000000, 17, 0);
    do_mul("mixed",   32'h12345678, 32'h9ABCDEF0, 32'h242D2080, 32, 0);
    do_mul("bp",      32'd7,        32'd6,        32'd42,       3,  5);

    // Abort a long operation with an asynchronous reset during its tenth BUSY cycle.
    out_ready = 1'b0;
    a         = 32'hFFFFFFFF;
    b         = 32'h80000000;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort.in_ready", {31'd0, in_ready}, 32'd1);
    check("abort.out_valid", {31'd0, out_valid}, 32'd0);
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.product", product, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.no_emit", {31'd0, out_valid}, 32'd0);
    do_mul("post_rst", 32'd2, 32'd3, 32'd6, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
